// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and defaults for the modexp_ctrl sequencer
package rsa_pkg;

   localparam int WORD_WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SQR      = 3'd1,
      SQR_WAIT = 3'd2,
      MUL      = 3'd3,
      MUL_WAIT = 3'd4,
      FIN      = 3'd5
   } modexp_state_e;

endpackage

// File: rtl/modexp_ctrl_if.sv
// rtl/modexp_ctrl_if.sv - modular-multiplier request/ack bus between sequencer and multiplier
interface modexp_ctrl_if #(
   parameter int WORD_WIDTH = rsa_pkg::WORD_WIDTH_DEF
) ();

   logic                  mul_req;
   logic [WORD_WIDTH-1:0] mul_a;
   logic [WORD_WIDTH-1:0] mul_b;
   logic [WORD_WIDTH-1:0] mul_n;
   logic                  mul_ack;
   logic [WORD_WIDTH-1:0] mul_p;

   modport master (
      output mul_req, mul_a, mul_b, mul_n,
      input  mul_ack, mul_p
   );

   modport slave (
      input  mul_req, mul_a, mul_b, mul_n,
      output mul_ack, mul_p
   );

endinterface

// File: rtl/msb_index.sv
// rtl/msb_index.sv - combinational index of the highest set bit (0 when the input is 0)
module msb_index #(
   parameter int WORD_WIDTH = rsa_pkg::WORD_WIDTH_DEF
) (
   input  logic [WORD_WIDTH-1:0]         value_i,
   output logic [$clog2(WORD_WIDTH)-1:0] index_o
);

   // Scan upward so the last set bit seen wins.
   always_comb begin
      index_o = '0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         if (value_i[i]) index_o = ($clog2(WORD_WIDTH))'(i);
      end
   end

endmodule

// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - left-to-right square-and-multiply sequencer; MODEXP_SKIP_LZ_EN skips leading-zero exponent bits
module modexp_ctrl
   import rsa_pkg::*;
#(
   parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] base_i,
   input  logic [WORD_WIDTH-1:0] exp_i,
   input  logic [WORD_WIDTH-1:0] mod_i,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [WORD_WIDTH-1:0] result_o,
   modexp_ctrl_if.master         mul_if
);

   localparam int                    IDX_W   = $clog2(WORD_WIDTH);
   localparam logic [IDX_W-1:0]      TOP_IDX = IDX_W'(WORD_WIDTH - 1);
   localparam logic [WORD_WIDTH-1:0] ONE     = WORD_WIDTH'(1);

   modexp_state_e         state_q, state_d;
   logic [WORD_WIDTH-1:0] base_q, base_d;
   logic [WORD_WIDTH-1:0] exp_q, exp_d;
   logic [WORD_WIDTH-1:0] mod_q, mod_d;
   logic [WORD_WIDTH-1:0] acc_q, acc_d;
   logic [WORD_WIDTH-1:0] result_q, result_d;
   logic [WORD_WIDTH-1:0] mul_a_q, mul_a_d;
   logic [WORD_WIDTH-1:0] mul_b_q, mul_b_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      start_idx;
   logic                  err_q, err_d;
   logic                  mul_req_q, mul_req_d;

`ifdef MODEXP_SKIP_LZ_EN
   msb_index #(.WORD_WIDTH(WORD_WIDTH)) u_msb_index (
      .value_i (exp_i),
      .index_o (start_idx)
   );
`else
   assign start_idx = TOP_IDX;
`endif

   // Next-state logic: one multiplier request per SQR/MUL visit, acc updated on ack.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      exp_d     = exp_q;
      mod_d     = mod_q;
      acc_d     = acc_q;
      result_d  = result_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      idx_d     = idx_q;
      err_d     = err_q;
      mul_req_d = mul_req_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               base_d = base_i;
               exp_d  = exp_i;
               mod_d  = mod_i;
               idx_d  = start_idx;
               acc_d  = ONE;
               err_d  = 1'b0;
               if (mod_i == '0) begin
                  err_d   = 1'b1;
                  acc_d   = '0;
                  state_d = FIN;
               end else if (exp_i == '0) begin
                  acc_d   = (mod_i == ONE) ? '0 : ONE;
                  state_d = FIN;
               end else begin
                  state_d = SQR;
               end
            end
         end
         SQR: begin
            mul_req_d = 1'b1;
            mul_a_d   = acc_q;
            mul_b_d   = acc_q;
            state_d   = SQR_WAIT;
         end
         SQR_WAIT: begin
            if (mul_if.mul_ack) begin
               mul_req_d = 1'b0;
               acc_d     = mul_if.mul_p;
               if (exp_q[idx_q]) begin
                  state_d = MUL;
               end else if (idx_q == '0) begin
                  state_d = FIN;
               end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = SQR;
               end
            end
         end
         MUL: begin
            mul_req_d = 1'b1;
            mul_a_d   = acc_q;
            mul_b_d   = base_q;
            state_d   = MUL_WAIT;
         end
         MUL_WAIT: begin
            if (mul_if.mul_ack) begin
               mul_req_d = 1'b0;
               acc_d     = mul_if.mul_p;
               if (idx_q == '0) begin
                  state_d = FIN;
               end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = SQR;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // The result register is loaded as FIN is entered so it is valid with done.
      if (state_d == FIN) result_d = acc_d;
   end

   // State and datapath registers; reset aborts any in-flight request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         base_q    <= '0;
         exp_q     <= '0;
         mod_q     <= '0;
         acc_q     <= ONE;
         result_q  <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         mul_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         exp_q     <= exp_d;
         mod_q     <= mod_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         mul_req_q <= mul_req_d;
      end
   end

   assign busy           = (state_q != IDLE);
   assign done           = (state_q == FIN);
   assign err            = err_q;
   assign result_o       = result_q;
   assign mul_if.mul_req = mul_req_q;
   assign mul_if.mul_a   = mul_a_q;
   assign mul_if.mul_b   = mul_b_q;
   assign mul_if.mul_n   = mod_q;

endmodule

// File: doc/modexp_ctrl.md
MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, width of base, exponent, modulus and result.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request one exponentiation; sampled only in IDLE.
REQ-005 SHALL have ports base_i, exp_i, mod_i  input  WORD_WIDTH  operands B, E, N; defined results require B < N.
REQ-006 SHALL have port busy  output  1  high from start acceptance until the done cycle inclusive.
REQ-007 SHALL have port done  output  1  single-cycle completion pulse.
REQ-008 SHALL have port err  output  1  valid with done; high when N == 0.
REQ-009 SHALL have port result_o  output  WORD_WIDTH  B^E mod N; held from done until the next accepted start.
REQ-010 SHALL have ports mul_req  output  1  and mul_a, mul_b, mul_n  output  WORD_WIDTH  modular-multiply request and operands.
REQ-011 SHALL have ports mul_ack  input  1  and mul_p  input  WORD_WIDTH  multiplier completion pulse and product (a*b mod n).

Function
REQ-012 SHALL latch base_i, exp_i and mod_i on the clk edge where start is high in IDLE; start outside IDLE SHALL be ignored.
REQ-013 SHALL implement left-to-right square-and-multiply: acc = 1; for each bit i from top index to 0: acc = acc*acc mod N; if E[i], acc = acc*B mod N.
REQ-014 SHALL have states IDLE, SQR, SQR_WAIT, MUL, MUL_WAIT, FIN; IDLE->SQR on start; SQR->SQR_WAIT; SQR_WAIT->MUL on ack if E[i], else SQR (next bit) or FIN (i == 0); MUL->MUL_WAIT; MUL_WAIT->SQR or FIN on ack; FIN->IDLE.
REQ-015 SHALL assert mul_req the cycle after entering SQR or MUL and hold it and mul_a/mul_b/mul_n stable until the cycle mul_ack is high; mul_req SHALL be low the cycle after ack.
REQ-016 SHALL capture mul_p into acc on the mul_ack cycle; mul_ack outside SQR_WAIT/MUL_WAIT SHALL be ignored.
REQ-017 SHALL pulse done for one cycle in FIN with result_o = acc and busy high; IDLE is re-entered on the following cycle.
REQ-018 SHALL, for N == 0, skip all multiplier requests, go IDLE->FIN, and report err = 1, result_o = 0.
REQ-019 SHALL, for E == 0 and N != 0, skip all multiplier requests and report result_o = 1, or 0 when N == 1.
REQ-020 SHALL tolerate arbitrary mul_ack latency (>= 1 cycle) without loss of state.

Reset
REQ-021 SHALL, while rst is low, force state IDLE, busy = 0, done = 0, err = 0, mul_req = 0, result_o = 0, acc = 1, operand registers = 0.
REQ-022 SHALL abort any in-flight operation on reset, drop mul_req, and leave no pending state after rst deasserts.

Configuration
REQ-023 SHALL, when MODEXP_SKIP_LZ_EN is defined, start iteration at the highest set bit of E (leading-zero iterations skipped; identical result, fewer requests).
REQ-024 SHALL, when MODEXP_SKIP_LZ_EN is undefined, always start at bit WORD_WIDTH-1 (fixed request pattern per E popcount).

Structure
REQ-025 SHALL take the state enum typedef and WORD_WIDTH default from shared package rsa_pkg.
REQ-026 SHALL place the highest-set-bit search in sub-module msb_index (combinational, used only with MODEXP_SKIP_LZ_EN).

Verification
REQ-027 SHALL check B=4, E=13, N=497, 1-cycle ack -> result_o = 445, err = 0; 35 requests without macro, 7 with macro.
REQ-028 SHALL check B=4, E=13, N=497 with 5-cycle ack delay -> result_o = 445; mul_a/mul_b/mul_n stable while mul_req high.
REQ-029 SHALL check E=0, N=7 -> result_o = 1, zero requests; E=0, N=1 -> result_o = 0; N=0 -> err = 1, result_o = 0.
REQ-030 SHALL check start pulsed again mid-operation -> ignored; first result 445 unchanged; busy stays high.
REQ-031 SHALL check rst low during MUL_WAIT -> mul_req, busy low immediately; next start with B=3, E=5, N=7 -> result_o = 5.
